t_from_d_counter: RTL

Synchronous T-flip-flop block built from D flip-flops: each bit's D input is driven as `T_i XOR Q_i`. Bits are chained into a WIDTH-bit up/down counter with enable, parallel load and terminal-count flag. It is the counterpart of the D-from-T flip-flop conversion. It serves as the toggle/count primitive for the counter and divider blocks that follow it.

---
 rtl/t_from_d_counter.sv | 72 +++++++
 1 files changed

// File: rtl/t_from_d_counter.sv
// t_from_d_counter: WIDTH-stage T flip-flop counter built from D flops.
// Every stage samples D = t ^ Q on the common clock; the toggle terms form
// a carry/borrow chain, so there is no ripple clocking anywhere.
// Adds up/down direction, synchronous parallel load, a registered terminal
// count flag and a registered mask of the stages that toggled.
module t_from_d_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             T,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_bar,
    output logic             tc,
    output logic [WIDTH-1:0] tog
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] tog_q;
    logic [WIDTH-1:0] tog_d;
    logic             tc_q;
    logic             tc_d;
    logic [WIDTH-1:0] t_vec;
    logic             run;

    // Toggle terms: stage i toggles when T is high and all lower stages are
    // ones (counting up) or zeros (counting down).
    always_comb begin
        t_vec = '0;
        run   = T;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            t_vec[i] = run;
            run      = run & (up ? q_q[i] : ~q_q[i]);
        end
    end

    // Next state: load wins over toggling; with T low t_vec is zero, which
    // holds Q and clears the toggle mask. tc looks at the value Q is about
    // to take, using the direction sampled on this same edge.
    always_comb begin
        q_d   = q_q ^ t_vec;
        tog_d = t_vec;
        if (load) begin
            q_d   = load_val;
            tog_d = q_q ^ load_val;
        end
        tc_d = up ? (&q_d) : ~(|q_d);
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q   <= '0;
            tog_q <= '0;
            tc_q  <= 1'b0;
        end else begin
            q_q   <= q_d;
            tog_q <= tog_d;
            tc_q  <= tc_d;
        end
    end

    assign Q     = q_q;
    assign Q_bar = ~q_q;
    assign tc    = tc_q;
    assign tog   = tog_q;

endmodule
